// File: rtl/systolic_seq_if.sv
// Result-row stream from the systolic sequencer to its consumer.
// The master drives valid/row/data and the slave returns ready.
interface systolic_seq_if #(
    parameter int ARRAY_SIZE = 4,
    parameter int ACC_WIDTH  = 32
);
    logic                              res_valid;
    logic                              res_ready;
    logic [$clog2(ARRAY_SIZE)-1:0]     res_row;
    logic [ARRAY_SIZE*ACC_WIDTH-1:0]   res_data;

    modport master (output res_valid, res_row, res_data, input res_ready);
    modport slave  (input res_valid, res_row, res_data, output res_ready);
endinterface

// File: rtl/systolic_seq.sv
// Tile sequencer for the output-stationary systolic MAC array: buffers one tile of
// operands, clears the array, feeds skewed operands, drains, then returns C row by row.
module systolic_seq #(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int K_MAX      = 16,
    parameter int DRAIN_CYC  = 2*ARRAY_SIZE-1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic [$clog2(K_MAX+1)-1:0]                k_len,
    output logic                                      busy,
    output logic                                      done,
    input  logic                                      wr_en,
    input  logic                                      wr_sel,
    input  logic [$clog2(K_MAX)-1:0]                  wr_addr,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]          wr_data,
    output logic                                      arr_enable,
    output logic                                      arr_clear,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]          arr_a,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]          arr_b,
    input  logic [ARRAY_SIZE*ARRAY_SIZE*ACC_WIDTH-1:0] c_in,
    systolic_seq_if.master                            res
);
    localparam int KL_W   = $clog2(K_MAX+1);
    localparam int ADDR_W = $clog2(K_MAX);
    localparam int ROW_W  = $clog2(ARRAY_SIZE);
    localparam int LANE_W = ARRAY_SIZE*DATA_WIDTH;
    localparam int ROWD_W = ARRAY_SIZE*ACC_WIDTH;
    localparam int CNT_W  = $clog2(K_MAX + ARRAY_SIZE + DRAIN_CYC);

    localparam logic [CNT_W-1:0] FEED_LAST_OFS = CNT_W'(ARRAY_SIZE-2);
    localparam logic [CNT_W-1:0] DRAIN_LAST    = CNT_W'(DRAIN_CYC-1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_OUT} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [KL_W-1:0]     klen_q, klen_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                snap;
    logic                busy_d, done_d, enable_d, clear_d, valid_q, valid_d;
    logic [LANE_W-1:0]   arr_a_d, arr_b_d;
    logic [ROWD_W-1:0]   data_q, data_d;

    logic [LANE_W-1:0]   a_buf    [K_MAX];
    logic [LANE_W-1:0]   b_buf    [K_MAX];
    logic [ROWD_W-1:0]   result_q [ARRAY_SIZE];

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        klen_d  = klen_q;
        row_d   = row_q;
        snap    = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && k_len != '0) begin
                    state_d = S_CLEAR;
                    klen_d  = (k_len > KL_W'(K_MAX)) ? KL_W'(K_MAX) : k_len;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == CNT_W'(klen_q) + FEED_LAST_OFS) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_OUT;
                    row_d   = '0;
                    snap    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (valid_q && res.res_ready) begin
                    if (row_q == ROW_W'(ARRAY_SIZE-1)) begin
                        state_d = S_IDLE;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from the next state so they register in step with it.
        busy_d   = (state_d != S_IDLE);
        clear_d  = (state_d == S_CLEAR);
        enable_d = (state_d == S_FEED) || (state_d == S_DRAIN);
        valid_d  = (state_d == S_OUT);

        // Lane i is delayed by i cycles; entry t-i is valid while it lies inside 0..klen-1.
        arr_a_d = '0;
        arr_b_d = '0;
        if (state_d == S_FEED) begin
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                if (cnt_d >= CNT_W'(i) && (cnt_d - CNT_W'(i)) < CNT_W'(klen_q)) begin
                    arr_a_d[i*DATA_WIDTH +: DATA_WIDTH] =
                        a_buf[ADDR_W'(cnt_d - CNT_W'(i))][i*DATA_WIDTH +: DATA_WIDTH];
                    arr_b_d[i*DATA_WIDTH +: DATA_WIDTH] =
                        b_buf[ADDR_W'(cnt_d - CNT_W'(i))][i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end

        data_d = '0;
        if (state_d == S_OUT) begin
            data_d = snap ? c_in[0 +: ROWD_W] : result_q[row_d];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            klen_q     <= '0;
            row_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            arr_enable <= 1'b0;
            arr_clear  <= 1'b0;
            arr_a      <= '0;
            arr_b      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            klen_q     <= klen_d;
            row_q      <= row_d;
            busy       <= busy_d;
            done       <= done_d;
            arr_enable <= enable_d;
            arr_clear  <= clear_d;
            arr_a      <= arr_a_d;
            arr_b      <= arr_b_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
        end
    end

    // NOTE: buffers and the result snapshot have no reset; they are always written before being read.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == S_IDLE) begin
            if (wr_sel) b_buf[wr_addr] <= wr_data;
            else        a_buf[wr_addr] <= wr_data;
        end
        if (snap) begin
            for (int r = 0; r < ARRAY_SIZE; r++) begin
                result_q[r] <= c_in[r*ROWD_W +: ROWD_W];
            end
        end
    end

    assign res.res_valid = valid_q;
    assign res.res_row   = row_q;
    assign res.res_data  = data_q;
endmodule
